apb_seq_cpu: RTL and testbench

//  Parametrised second-generation command sequencer CPU. Fetches fixed-width

---
 rtl/apb_seq_cpu.sv | 196 +++++++++++++++++++
 tb/tb_apb_seq_cpu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_seq_cpu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_seq_cpu : command sequencer CPU driving APB-style peripheral transfers |
// | Optional: define APB_TIMEOUT_EN to abort stalled transfers with an error  |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module apb_seq_cpu #(
  parameter int NUM_PERIPH  = 4,
  parameter int PADDR_W     = 8,
  parameter int PDATA_W     = 19,
  parameter int PC_W        = 12,
  parameter int LOOP_W      = 8,
  parameter int TIMEOUT_CYC = 255,
  localparam int SEL_W      = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1,
  localparam int IW         = 3 + SEL_W + PADDR_W + PDATA_W
) (
  input  logic                  CCLK,
  input  logic                  CPURESET,
  input  logic                  RUN,
  output logic [PC_W-1:0]       imem_addr,
  output logic                  imem_rden,
  input  logic [IW-1:0]         imem_rdata,
  output logic                  APBMASTERENABLE,
  output logic [NUM_PERIPH-1:0] CPUSEL,
  output logic [PADDR_W-1:0]    addr,
  output logic [PDATA_W-1:0]    data,
  output logic                  PWRITE,
  input  logic                  CPUPREADY,
  input  logic [PDATA_W-1:0]    PRDATA,
  output logic [PDATA_W-1:0]    rd_data,
  output logic                  CPUDONE,
  output logic                  CPUPERPHRESET,
  output logic                  err
);

  localparam logic [2:0] c_op_nop  = 3'd0;
  localparam logic [2:0] c_op_pwr  = 3'd1;
  localparam logic [2:0] c_op_prd  = 3'd2;
  localparam logic [2:0] c_op_jmp  = 3'd3;
  localparam logic [2:0] c_op_loop = 3'd4;
  localparam logic [2:0] c_op_djnz = 3'd5;
  localparam logic [2:0] c_op_prst = 3'd6;
  localparam logic [2:0] c_op_halt = 3'd7;
  localparam logic [SEL_W:0] c_num_periph = (SEL_W + 1)'(NUM_PERIPH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LOAD     = 3'd2,
    S_EXEC     = 3'd3,
    S_APB_WAIT = 3'd4,
    S_HALT     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t                r_state;
  logic [PC_W-1:0]       r_pc;
  logic [LOOP_W-1:0]     r_cnt;
  logic [IW-1:0]         r_ir;
  logic                  r_en;
  logic [NUM_PERIPH-1:0] r_sel;
  logic [PADDR_W-1:0]    r_addr;
  logic [PDATA_W-1:0]    r_data;
  logic                  r_write;
  logic [PDATA_W-1:0]    r_rd_data;
  logic                  r_perph_rst;
  logic                  r_err;

  logic [2:0]            w_opc;
  logic [SEL_W-1:0]      w_sel;
  logic [PADDR_W-1:0]    w_addr;
  logic [PDATA_W-1:0]    w_data;
  logic [LOOP_W-1:0]     w_cnt_dec;
  logic                  w_bad_sel;

  assign w_opc     = r_ir[IW-1 -: 3];
  assign w_sel     = r_ir[PADDR_W + PDATA_W +: SEL_W];
  assign w_addr    = r_ir[PDATA_W +: PADDR_W];
  assign w_data    = r_ir[PDATA_W-1:0];
  assign w_cnt_dec = r_cnt - LOOP_W'(1);
  assign w_bad_sel = ({1'b0, w_sel} >= c_num_periph);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge CCLK) begin
    if (CPURESET) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_cnt       <= '0;
      r_ir        <= '0;
      r_en        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_rd_data   <= '0;
      r_perph_rst <= 1'b1;
      r_err       <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_perph_rst <= 1'b0;
      case (r_state)
        S_IDLE:  if (RUN) r_state <= S_FETCH;
        // RUN is honoured only at instruction boundaries; PC is kept for resume
        S_FETCH: r_state <= RUN ? S_LOAD : S_IDLE;
        S_LOAD: begin
          r_ir    <= imem_rdata;
          r_pc    <= r_pc + PC_W'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (w_opc)
            c_op_pwr, c_op_prd: begin
              if (w_bad_sel) begin
                r_err   <= 1'b1;
                r_state <= S_ERR;
              end else begin
                r_en    <= 1'b1;
                r_sel   <= NUM_PERIPH'(1) << w_sel;
                r_addr  <= w_addr;
                r_data  <= w_data;
                r_write <= (w_opc == c_op_pwr);
                r_state <= S_APB_WAIT;
`ifdef APB_TIMEOUT_EN
                r_tmo   <= '0;
`endif
              end
            end
            c_op_jmp:  r_pc  <= r_ir[PC_W-1:0];
            c_op_loop: r_cnt <= r_ir[LOOP_W-1:0];
            c_op_djnz: begin
              if (r_cnt != '0) begin
                r_cnt <= w_cnt_dec;
                if (w_cnt_dec != '0) r_pc <= r_ir[PC_W-1:0];
              end
            end
            c_op_prst: r_perph_rst <= 1'b1;
            c_op_halt: r_state <= S_HALT;
            default:   ;
          endcase
        end
        S_APB_WAIT: begin
          // Ready is checked first so a response on the final count still completes
          if (CPUPREADY) begin
            r_en    <= 1'b0;
            r_sel   <= '0;
            if (!r_write) r_rd_data <= PRDATA;
            r_state <= S_FETCH;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_tmo == c_tmo_last) begin
            r_en    <= 1'b0;
            r_sel   <= '0;
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end
        S_HALT: begin
          if (!RUN) begin
            r_pc    <= '0;
            r_state <= S_IDLE;
          end
        end
        S_ERR:   ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr       = r_pc;
  assign imem_rden       = (r_state == S_FETCH);
  assign APBMASTERENABLE = r_en;
  assign CPUSEL          = r_sel;
  assign addr            = r_addr;
  assign data            = r_data;
  assign PWRITE          = r_write;
  assign rd_data         = r_rd_data;
  assign CPUDONE         = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR);
  assign CPUPERPHRESET   = r_perph_rst;
  assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_seq_cpu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_seq_cpu : directed self-checking bench for apb_seq_cpu             |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_apb_seq_cpu;
  localparam int IW = 32;

  logic        CCLK = 1'b0;
  logic        CPURESET = 1'b1;
  logic        RUN = 1'b0;
  logic [11:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata;
  logic        APBMASTERENABLE;
  logic [3:0]  CPUSEL;
  logic [7:0]  addr;
  logic [18:0] data;
  logic        PWRITE;
  logic        CPUPREADY;
  logic [18:0] PRDATA = '0;
  logic [18:0] rd_data;
  logic        CPUDONE;
  logic        CPUPERPHRESET;
  logic        err;

  always #5 CCLK = ~CCLK;

  apb_seq_cpu #(.TIMEOUT_CYC(8)) dut (
    .CCLK(CCLK), .CPURESET(CPURESET), .RUN(RUN),
    .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_rdata(imem_rdata),
    .APBMASTERENABLE(APBMASTERENABLE), .CPUSEL(CPUSEL), .addr(addr), .data(data),
    .PWRITE(PWRITE), .CPUPREADY(CPUPREADY), .PRDATA(PRDATA), .rd_data(rd_data),
    .CPUDONE(CPUDONE), .CPUPERPHRESET(CPUPERPHRESET), .err(err)
  );

  // Second instance with three peripherals so an out-of-range select is encodable
  logic        e_rst = 1'b1;
  logic        e_run = 1'b0;
  logic [11:0] e_imem_addr;
  logic        e_rden;
  logic [31:0] e_rdata;
  logic        e_en;
  logic [2:0]  e_sel;
  logic [7:0]  e_addr;
  logic [18:0] e_data;
  logic        e_pwrite;
  logic [18:0] e_rd_data;
  logic        e_done;
  logic        e_prst;
  logic        e_err;
  logic        e_en_seen = 1'b0;

  apb_seq_cpu #(.NUM_PERIPH(3), .TIMEOUT_CYC(8)) dut_e (
    .CCLK(CCLK), .CPURESET(e_rst), .RUN(e_run),
    .imem_addr(e_imem_addr), .imem_rden(e_rden), .imem_rdata(e_rdata),
    .APBMASTERENABLE(e_en), .CPUSEL(e_sel), .addr(e_addr), .data(e_data),
    .PWRITE(e_pwrite), .CPUPREADY(1'b1), .PRDATA(19'h0), .rd_data(e_rd_data),
    .CPUDONE(e_done), .CPUPERPHRESET(e_prst), .err(e_err)
  );

  function automatic logic [31:0] mk(input int opc, input int sel, input int a, input int d);
    return {opc[2:0], sel[1:0], a[7:0], d[18:0]};
  endfunction

  logic [31:0] mem [0:4095];
  always @(posedge CCLK) if (imem_rden) imem_rdata <= mem[imem_addr];
  always @(posedge CCLK) if (e_rden) e_rdata <= mk(1, 3, 8'h10, 19'h5);
  always @(posedge CCLK) if (e_en) e_en_seen <= 1'b1;

  // Peripheral responder: ready after ready_delay enable cycles, logs completed transfers
  int          ready_delay = 0;
  int          wait_cnt = 0;
  int          xfer_cnt = 0;
  int          last_len = 0;
  logic [3:0]  last_sel = '0;
  logic [7:0]  last_addr = '0;
  logic [18:0] last_data = '0;
  assign CPUPREADY = APBMASTERENABLE && (wait_cnt == ready_delay);
  always @(posedge CCLK) begin
    if (APBMASTERENABLE && CPUPREADY) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_len  <= wait_cnt + 1;
      last_sel  <= CPUSEL;
      last_addr <= addr;
      last_data <= data;
    end
    wait_cnt <= APBMASTERENABLE ? wait_cnt + 1 : 0;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    CPURESET = 1'b1;
    RUN = 1'b0;
    repeat (2) @(posedge CCLK);
    @(negedge CCLK);
    CPURESET = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic wait_en(input logic val, input int max, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge CCLK);
      if (APBMASTERENABLE === val) ok = 1'b1;
    end
    if (!ok) check(tag, 32'(APBMASTERENABLE), 32'(val));
  endtask

  task automatic wait_done(input int max, input string tag);
    bit ok = 1'b0;
    repeat (3) @(negedge CCLK);
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge CCLK);
      if (CPUDONE === 1'b1) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_fetch(input logic [11:0] tgt, input int max, input string tag, output int perph_hi);
    bit ok = 1'b0;
    perph_hi = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge CCLK);
      if (CPUPERPHRESET === 1'b1) perph_hi++;
      if (imem_rden === 1'b1 && imem_addr === tgt) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int base;
    int perph_hi;
    bit seen;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset state
    @(negedge CCLK);
    check("rst_done", 32'(CPUDONE), 32'd1);
    check("rst_perph", 32'(CPUPERPHRESET), 32'd1);
    check("rst_en", 32'(APBMASTERENABLE), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rden", 32'(imem_rden), 32'd0);
    CPURESET = 1'b0;
    @(negedge CCLK);
    check("rst_perph_clear", 32'(CPUPERPHRESET), 32'd0);

    // PWR sel=2 addr=0x15 data=0x1234, ready after 3 enable cycles
    do_reset();
    mem[0] = mk(1, 2, 8'h15, 19'h1234);
    mem[1] = mk(7, 0, 0, 0);
    ready_delay = 3;
    base = xfer_cnt;
    RUN = 1'b1;
    wait_en(1'b1, 20, "pwr_en_rise");
    check("pwr_sel", 32'(CPUSEL), 32'h4);
    check("pwr_addr", 32'(addr), 32'h15);
    check("pwr_data", 32'(data), 32'h1234);
    check("pwr_write", 32'(PWRITE), 32'd1);
    wait_en(1'b0, 20, "pwr_en_fall");
    check("pwr_len", 32'(last_len), 32'd4);
    check("pwr_next_rden", 32'(imem_rden), 32'd1);
    check("pwr_next_pc", 32'(imem_addr), 32'd1);
    check("pwr_sel_drop", 32'(CPUSEL), 32'd0);
    wait_done(20, "pwr_halt");
    check("pwr_xfers", 32'(xfer_cnt - base), 32'd1);
    check("halt_pc", 32'(imem_addr), 32'd2);
    RUN = 1'b0;
    repeat (2) @(negedge CCLK);
    check("halt_exit_pc", 32'(imem_addr), 32'd0);
    check("halt_exit_done", 32'(CPUDONE), 32'd1);

    // PRD sel=0, data returned with immediate ready
    do_reset();
    mem[0] = mk(2, 0, 8'h22, 0);
    mem[1] = mk(7, 0, 0, 0);
    PRDATA = 19'h7ABC;
    ready_delay = 0;
    RUN = 1'b1;
    wait_en(1'b1, 20, "prd_en_rise");
    check("prd_write", 32'(PWRITE), 32'd0);
    check("prd_sel", 32'(CPUSEL), 32'h1);
    check("prd_addr", 32'(addr), 32'h22);
    wait_done(20, "prd_halt");
    check("prd_rd_data", 32'(rd_data), 32'h7ABC);
    check("prd_len", 32'(last_len), 32'd1);

    // LOOP 3 around a PWR body, then a distinct fall-through PWR
    do_reset();
    mem[0] = mk(4, 0, 0, 3);
    mem[1] = mk(1, 1, 8'h40, 19'h55);
    mem[2] = mk(5, 0, 0, 1);
    mem[3] = mk(1, 3, 8'h41, 19'h66);
    mem[4] = mk(7, 0, 0, 0);
    ready_delay = 1;
    base = xfer_cnt;
    RUN = 1'b1;
    wait_done(200, "loop_halt");
    check("loop_xfers", 32'(xfer_cnt - base), 32'd4);
    check("loop_last_addr", 32'(last_addr), 32'h41);
    check("loop_last_sel", 32'(last_sel), 32'h8);
    check("loop_last_data", 32'(last_data), 32'h66);

    // PRST pulse, then JMP to 0xFFF and PC wrap to 0
    do_reset();
    mem[0] = mk(6, 0, 0, 0);
    mem[1] = mk(3, 0, 0, 12'hFFF);
    RUN = 1'b1;
    wait_fetch(12'hFFF, 40, "jmp_reach_fff", perph_hi);
    check("prst_width", 32'(perph_hi), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CCLK);
      if (imem_rden === 1'b1) seen = 1'b1;
    end
    check("wrap_fetch_seen", 32'(seen), 32'd1);
    check("wrap_pc", 32'(imem_addr), 32'd0);
    RUN = 1'b0;
    wait_done(20, "run_stop_idle");
    check("run_stop_err", 32'(err), 32'd0);

    // Peripheral never answers
    do_reset();
    mem[0] = mk(1, 1, 8'h03, 19'h9);
    ready_delay = 1000;
    RUN = 1'b1;
    repeat (100) @(negedge CCLK);
`ifdef APB_TIMEOUT_EN
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_en", 32'(APBMASTERENABLE), 32'd0);
    check("tmo_done", 32'(CPUDONE), 32'd1);
`else
    check("stall_en", 32'(APBMASTERENABLE), 32'd1);
    check("stall_err", 32'(err), 32'd0);
    check("stall_done", 32'(CPUDONE), 32'd0);
`endif
    do_reset();
    check("stall_rst_en", 32'(APBMASTERENABLE), 32'd0);
    check("stall_rst_err", 32'(err), 32'd0);
    ready_delay = 0;

    // Out-of-range select on a three-peripheral instance
    @(negedge CCLK);
    e_rst = 1'b0;
    e_run = 1'b1;
    repeat (10) @(negedge CCLK);
    check("badsel_err", 32'(e_err), 32'd1);
    check("badsel_done", 32'(e_done), 32'd1);
    check("badsel_no_en", 32'(e_en_seen), 32'd0);
    e_run = 1'b0;
    repeat (3) @(negedge CCLK);
    check("badsel_sticky", 32'(e_err), 32'd1);
    e_rst = 1'b1;
    @(negedge CCLK);
    check("badsel_rst_clear", 32'(e_err), 32'd0);
    e_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
